cdb_writeback: RTL
==================

CDB_WRITEBACK -- requirements
Module: cdb_writeback

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, exposed as the first two ports below.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- addValid  in  1  adder unit result valid.
- addTag  in  3  adder reservation-station tag; 0 means no tag.
- addResult  in  16  adder result.
- addReady  out  1  adder result accepted this cycle.
- mulValid / mulTag / mulResult / mulReady  same widths and meanings as above, for the multiplier unit.
- issueValid  in  1  issue is updating the register status table.
- issueDest  in  3  destination FP register; 0 means none.
- issueTag  in  3  tag now producing issueDest.
- qiAddr  in  3  status read address.
- qiTag  out  3  Qi of qiAddr; combinational.
- qiBusy  out  1  busy bit of qiAddr; combinational; 0 for address 0.
- cdbValid / cdbTag / cdbData  out  1/3/16  common data bus broadcast.
- dataIn / dataAddress / writeEnable  out  16/3/1  register-file write port.

Function
REQ-002 Status table: for registers 1..7, the module SHALL hold a busy bit and a 3-bit Qi per register.
REQ-003 Arbitration: addReady and mulReady SHALL be combinational grants; at most one is high per cycle.
- A lone valid source SHALL be granted.
- When both sources are valid, the source selected by the round-robin pointer SHALL be granted, and the pointer SHALL then move to the other source.
- Uncontested grants SHALL NOT move the pointer.
REQ-004 No backpressure: a granted result SHALL be accepted at that rising edge, giving throughput of 1 result per cycle.
REQ-005 Broadcast latency: a result accepted at edge N SHALL drive cdbValid=1, cdbTag and cdbData for exactly the cycle after edge N.
- cdbValid SHALL be 0 in any cycle with no accepted result.
REQ-006 Tag-0 results SHALL be accepted (ready high) and dropped, with cdbValid=0.
REQ-007 Writeback match: while cdbValid=1, the module SHALL search registers 1..7 for busy=1 and Qi=cdbTag, using status before this cycle's issue update.
- On a match (at most one), writeEnable=1, dataAddress=matched register, dataIn=cdbData.
- With no match (WAW overwrite), writeEnable=0.
- writeEnable SHALL be combinational from registered CDB state.
REQ-008 At the edge ending a matched broadcast cycle, the matched register's busy bit SHALL clear and its Qi SHALL become 0.
REQ-009 Issue: at a rising edge with issueValid=1 and issueDest≠0, the module SHALL set busy[issueDest]=1 and Qi[issueDest]=issueTag.
- issueDest=0 SHALL be ignored.
REQ-010 When an issue and a writeback clear target the same register at the same edge, the issue SHALL win (busy=1, new Qi), and the data write of REQ-007 SHALL still occur.
REQ-011 When dataAddress is 0, writeEnable SHALL never be 1.

Reset
REQ-012 While reset_n=0, the module SHALL force the following, regardless of clock:
- all busy bits 0, all Qi 0;
- cdbValid 0, cdbTag 0, cdbData 0;
- writeEnable 0, dataIn 0, dataAddress 0;
- round-robin pointer set to adder.
REQ-013 Reset asserted mid-broadcast SHALL drop the in-flight result with no register write.

Configuration
REQ-014 Macro WB_STALL_COUNT_EN:
- When defined, the module SHALL add port stallCount (out, 16). stallCount SHALL increment, saturating at 16'hFFFF, at each edge where a source is valid but not granted, and SHALL reset to 0.
- When undefined, the port and counter SHALL be absent, with function otherwise identical.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- Issue dest=3 tag=5; then addValid tag=5 result=16'h00AA -> cdbValid next cycle, writeEnable=1, dataAddress=3, dataIn=16'h00AA; then qiBusy(3)=0.
- addValid and mulValid both high for 3 cycles, pointer at reset -> grants add, mul, add; with macro defined, stallCount=3.
- Issue dest=2 tag=1, later issue dest=2 tag=4, then broadcast tag=1 -> cdbValid=1, writeEnable=0, Qi(2)=4.
- Broadcast tag=6 matching R5 while issue dest=5 tag=2 at the same edge -> write R5, then busy(5)=1, Qi(5)=2.
- mulValid tag=0 result=16'h1234 -> mulReady=1, cdbValid stays 0, no write.
- reset_n pulsed low in the cycle cdbValid=1 -> outputs 0 immediately, all busy 0, no write.

Source files
------------

// File: rtl/cdb_writeback.sv
// cdb_writeback: common data bus arbitration, broadcast and register writeback
// for a two-unit (adder / multiplier) Tomasulo-style datapath.
//
// - Round-robin arbitration between the adder and multiplier result ports.
// - There is no backpressure, so one result can be accepted per cycle.
// - A registered CDB broadcast drives the register-file write port. The write
//   happens only when a busy register still waits on the broadcast tag.
// - A register status table (busy, Qi) is kept for registers 1..7.
//   Register 0 is permanently idle.
//
// Optional feature: define WB_STALL_COUNT_EN to add the stallCount output.
// stallCount is a saturating count of edges where a valid source lost
// arbitration.

module cdb_writeback (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        addValid,
    input  logic [2:0]  addTag,
    input  logic [15:0] addResult,
    output logic        addReady,
    input  logic        mulValid,
    input  logic [2:0]  mulTag,
    input  logic [15:0] mulResult,
    output logic        mulReady,
    input  logic        issueValid,
    input  logic [2:0]  issueDest,
    input  logic [2:0]  issueTag,
    input  logic [2:0]  qiAddr,
    output logic [2:0]  qiTag,
    output logic        qiBusy,
    output logic        cdbValid,
    output logic [2:0]  cdbTag,
    output logic [15:0] cdbData,
    output logic [15:0] dataIn,
    output logic [2:0]  dataAddress,
    output logic        writeEnable
`ifdef WB_STALL_COUNT_EN
    ,
    output logic [15:0] stallCount
`endif
);

    // Round-robin pointer: 0 = adder has priority, 1 = multiplier has priority
    logic             rr_q, rr_d;

    // Registered broadcast
    logic             cdb_valid_q, cdb_valid_d;
    logic [2:0]       cdb_tag_q, cdb_tag_d;
    logic [15:0]      cdb_data_q, cdb_data_d;

    // Register status table. Entry 0 exists only so that indexing stays simple.
    // Entry 0 is held at zero.
    logic [7:0]       busy_q, busy_d;
    logic [7:0][2:0]  qi_q, qi_d;

    logic             add_gnt, mul_gnt, contested;
    logic             match_hit;
    logic [2:0]       match_idx;

    // Arbitration: a lone requester always wins; on contention the pointer decides
    always_comb begin
        contested = addValid && mulValid;
        if (contested) begin
            add_gnt = (rr_q == 1'b0);
            mul_gnt = (rr_q == 1'b1);
        end else begin
            add_gnt = addValid;
            mul_gnt = mulValid;
        end
    end

    assign addReady = add_gnt;
    assign mulReady = mul_gnt;

    // Next broadcast: tag-0 results are accepted but never put on the bus
    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        if (add_gnt && (addTag != 3'd0)) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = addTag;
            cdb_data_d  = addResult;
        end else if (mul_gnt && (mulTag != 3'd0)) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = mulTag;
            cdb_data_d  = mulResult;
        end
        rr_d = contested ? ~rr_q : rr_q;
    end

    // Broadcast register and arbitration pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= 3'd0;
            cdb_data_q  <= 16'd0;
            rr_q        <= 1'b0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            rr_q        <= rr_d;
        end
    end

    assign cdbValid = cdb_valid_q;
    assign cdbTag   = cdb_valid_q ? cdb_tag_q : 3'd0;
    assign cdbData  = cdb_valid_q ? cdb_data_q : 16'd0;

    // Writeback search over registers 1..7 using the current (pre-issue) status
    always_comb begin
        match_hit = 1'b0;
        match_idx = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (cdb_valid_q && busy_q[i] && (qi_q[i] == cdb_tag_q)) begin
                match_hit = 1'b1;
                match_idx = i[2:0];
            end
        end
    end

    assign writeEnable = match_hit && (match_idx != 3'd0);
    assign dataAddress = writeEnable ? match_idx : 3'd0;
    assign dataIn      = writeEnable ? cdb_data_q : 16'd0;

    // Status update: writeback clear first, so a same-edge issue overrides it
    always_comb begin
        busy_d = busy_q;
        qi_d   = qi_q;
        if (writeEnable) begin
            busy_d[dataAddress] = 1'b0;
            qi_d[dataAddress]   = 3'd0;
        end
        if (issueValid && (issueDest != 3'd0)) begin
            busy_d[issueDest] = 1'b1;
            qi_d[issueDest]   = issueTag;
        end
        busy_d[0] = 1'b0;
        qi_d[0]   = 3'd0;
    end

    // Status table register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            qi_q   <= '0;
        end else begin
            busy_q <= busy_d;
            qi_q   <= qi_d;
        end
    end

    // Combinational status read; entry 0 is constant zero
    assign qiTag  = qi_q[qiAddr];
    assign qiBusy = busy_q[qiAddr];

`ifdef WB_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    // Stall counter next value: one count per edge where a valid source was refused
    always_comb begin
        stall_d = stall_q;
        if (((addValid && !add_gnt) || (mulValid && !mul_gnt)) && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    // Stall counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) stall_q <= 16'd0;
        else          stall_q <= stall_d;
    end

    assign stallCount = stall_q;
`endif

endmodule
